store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/sb_pkg.sv | 17 +
 rtl/sb_fwd_match.sv | 34 +++
 rtl/store_buffer.sv | 64 ++++++
 tb/tb_store_buffer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// sb_pkg: shared types and sizing for the store buffer.
// Contents: default data width and depth, pointer/count width helper,
// and the buffered entry record {addr, data}.
package sb_pkg;
   localparam int SB_XLEN  = 32;
   localparam int SB_DEPTH = 4;
   function automatic int sb_ptr_w(input int depth);
      return $clog2(depth);
   endfunction
   localparam int SB_PTR_W = sb_ptr_w(SB_DEPTH);
   localparam int SB_CNT_W = SB_PTR_W + 1;
   // Entry width follows SB_XLEN; instantiate store_buffer with XLEN == SB_XLEN.
   typedef struct packed {
      logic [SB_XLEN-1:0] addr;
      logic [SB_XLEN-1:0] data;
   } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: youngest-first search of valid entries for a word-address hit.
// Ports: entries (storage array), rd_ptr/count (valid window, oldest first),
// addr (load byte address), hit (any match), data (youngest matching data).
module sb_fwd_match
   import sb_pkg::*;
#(
   parameter int XLEN  = SB_XLEN,
   parameter int DEPTH = SB_DEPTH,
   parameter int PTR_W = sb_ptr_w(DEPTH),
   parameter int CNT_W = PTR_W + 1
) (
   input  sb_entry_t          entries [DEPTH],
   input  logic [PTR_W-1:0]   rd_ptr,
   input  logic [CNT_W-1:0]   count,
   input  logic [XLEN-1:0]    addr,
   output logic               hit,
   output logic [XLEN-1:0]    data
);
   logic [PTR_W-1:0] idx;
   // Walk oldest to youngest; later matches overwrite earlier ones, so the
   // youngest matching store wins. Byte-offset bits are shifted out of the compare.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PTR_W'(i);
         if (CNT_W'(i) < count && ((entries[idx].addr ^ addr) >> 2) == '0) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: circular store FIFO between core and data memory with load forwarding.
// Ports: clk/reset (async, active-low); MemWrite/ALUResult/WriteData store request;
// ReadData load return (forwarded or MemRdata); Stall store rejected;
// bus_valid/bus_addr/bus_wdata/bus_ready drain to memory; Empty no entries held.
module store_buffer
   import sb_pkg::*;
#(
   parameter int XLEN  = SB_XLEN,
   parameter int DEPTH = SB_DEPTH
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            MemWrite,
   input  logic [XLEN-1:0] ALUResult,
   input  logic [XLEN-1:0] WriteData,
   output logic [XLEN-1:0] ReadData,
   input  logic [XLEN-1:0] MemRdata,
   output logic            Stall,
   output logic            bus_valid,
   output logic [XLEN-1:0] bus_addr,
   output logic [XLEN-1:0] bus_wdata,
   input  logic            bus_ready,
   output logic            Empty
);
   localparam int PTR_W = sb_ptr_w(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   sb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             drain, accept, hit;
   logic [XLEN-1:0]  fwd_data;
   assign bus_valid = count != '0;
   assign Empty     = count == '0;
   assign bus_addr  = mem[rd_ptr].addr;
   assign bus_wdata = mem[rd_ptr].data;
   assign drain     = bus_valid & bus_ready;
   // A full buffer still accepts when the oldest entry leaves in the same cycle.
   assign accept    = MemWrite & ((count != CNT_W'(DEPTH)) | drain);
   assign Stall     = MemWrite & ~accept;
   assign ReadData  = (!MemWrite && hit) ? fwd_data : MemRdata;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
         if (drain)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(accept) - CNT_W'(drain);
      end
   end
   // Entry storage is not reset; validity comes only from count.
   always_ff @(posedge clk) begin
      if (reset && accept) mem[wr_ptr] <= '{addr: ALUResult, data: WriteData};
   end
   sb_fwd_match #(.XLEN(XLEN), .DEPTH(DEPTH), .PTR_W(PTR_W), .CNT_W(CNT_W)) u_fwd (
      .entries (mem),
      .rd_ptr  (rd_ptr),
      .count   (count),
      .addr    (ALUResult),
      .hit     (hit),
      .data    (fwd_data)
   );
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scenario tasks plus a scoreboard model of the store buffer.
module tb_store_buffer;
   logic        clk = 1'b0;
   logic        reset, MemWrite, bus_ready;
   logic [31:0] ALUResult, WriteData, MemRdata;
   logic [31:0] ReadData, bus_addr, bus_wdata;
   logic        Stall, bus_valid, Empty;
   int tests = 0;
   int fails = 0;
   typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
   ent_t sbq[$];

   always #5 clk = ~clk;

   store_buffer #(.XLEN(32), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .ALUResult(ALUResult),
      .WriteData(WriteData), .ReadData(ReadData), .MemRdata(MemRdata),
      .Stall(Stall), .bus_valid(bus_valid), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_ready(bus_ready), .Empty(Empty)
   );

   // Scoreboard: expected stores queued on acceptance, popped on each bus handshake.
   logic [31:0] exp_rd;
   bit          acc;
   always @(negedge clk) begin
      if (!reset) sbq.delete();
      else begin
         exp_rd = MemRdata;
         if (!MemWrite)
            foreach (sbq[i]) if (sbq[i].a[31:2] == ALUResult[31:2]) exp_rd = sbq[i].d;
         acc = MemWrite && (sbq.size() < 4 || bus_ready);
         tests += 4;
         if (ReadData !== exp_rd) begin fails++; $display("FAIL sb_readdata: got %h expected %h", ReadData, exp_rd); end
         if (Stall !== (MemWrite && !acc)) begin fails++; $display("FAIL sb_stall: got %b expected %b", Stall, MemWrite && !acc); end
         if (bus_valid !== (sbq.size() != 0)) begin fails++; $display("FAIL sb_bus_valid: got %b expected %b", bus_valid, sbq.size() != 0); end
         if (Empty !== (sbq.size() == 0)) begin fails++; $display("FAIL sb_empty: got %b expected %b", Empty, sbq.size() == 0); end
         if (bus_valid === 1'b1 && bus_ready) begin
            tests++;
            if (sbq.size() == 0) begin
               fails++; $display("FAIL sb_unexpected_write: got addr %h expected no write", bus_addr);
            end else begin
               if (bus_addr !== sbq[0].a || bus_wdata !== sbq[0].d) begin
                  fails++;
                  $display("FAIL sb_drain: got %h/%h expected %h/%h", bus_addr, bus_wdata, sbq[0].a, sbq[0].d);
               end
               void'(sbq.pop_front());
            end
         end
         if (acc) sbq.push_back('{a: ALUResult, d: WriteData});
      end
   end

   task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
      @(posedge clk); #1;
      MemWrite = we; ALUResult = a; WriteData = d; bus_ready = rdy; MemRdata = $urandom;
   endtask

   task automatic drain_all();
      int n = 0;
      cyc(1'b0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      while (!Empty && n < 16) begin
         cyc(1'b0, 32'h0, 32'h0, 1'b1);
         @(negedge clk);
         n++;
      end
      tests++;
      if (Empty !== 1'b1) begin fails++; $display("FAIL drain_timeout: got Empty=%b expected 1", Empty); end
   endtask

   task automatic test_reset();
      reset = 1'b0; MemWrite = 1'b1; ALUResult = 32'h8; WriteData = 32'h5; bus_ready = 1'b1; MemRdata = 32'h0;
      @(negedge clk);
      tests += 3;
      if (Empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b expected 1", Empty); end
      if (bus_valid !== 1'b0) begin fails++; $display("FAIL reset_bus_valid: got %b expected 0", bus_valid); end
      if (Stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", Stall); end
      @(posedge clk); #1;
      reset = 1'b1; MemWrite = 1'b0;
   endtask

   task automatic test_single_store();
      cyc(1'b1, 32'h100, 32'hDEADBEEF, 1'b1);
      cyc(1'b0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      tests += 3;
      if (bus_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", bus_valid); end
      if (bus_addr !== 32'h100) begin fails++; $display("FAIL single_addr: got %h expected 00000100", bus_addr); end
      if (bus_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL single_data: got %h expected deadbeef", bus_wdata); end
      cyc(1'b0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      tests++;
      if (Empty !== 1'b1) begin fails++; $display("FAIL single_empty: got %b expected 1", Empty); end
   endtask

   task automatic test_forwarding();
      cyc(1'b1, 32'h40, 32'h11, 1'b0);
      cyc(1'b1, 32'h40, 32'h22, 1'b0);
      cyc(1'b0, 32'h40, 32'h0, 1'b0);
      @(negedge clk);
      tests++;
      if (ReadData !== 32'h22) begin fails++; $display("FAIL fwd_youngest: got %h expected 00000022", ReadData); end
      cyc(1'b0, 32'h42, 32'h0, 1'b0);
      @(negedge clk);
      tests++;
      if (ReadData !== 32'h22) begin fails++; $display("FAIL fwd_same_word: got %h expected 00000022", ReadData); end
      cyc(1'b0, 32'h44, 32'h0, 1'b0);
      @(negedge clk);
      tests++;
      if (ReadData !== MemRdata) begin fails++; $display("FAIL fwd_miss: got %h expected %h", ReadData, MemRdata); end
      cyc(1'b1, 32'h44, 32'h33, 1'b0);
      @(negedge clk);
      tests++;
      if (ReadData !== MemRdata) begin fails++; $display("FAIL fwd_store_cycle: got %h expected %h", ReadData, MemRdata); end
      drain_all();
   endtask

   task automatic test_full_stall();
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 32'h300 + 32'(k * 4), 32'hA0 + 32'(k), 1'b0);
         @(negedge clk);
         tests++;
         if (Stall !== (k == 4)) begin fails++; $display("FAIL full_stall_%0d: got %b expected %b", k, Stall, k == 4); end
      end
      cyc(1'b1, 32'h400, 32'hBB, 1'b0);
      @(negedge clk);
      tests++;
      if (Stall !== 1'b1) begin fails++; $display("FAIL full_hold: got %b expected 1", Stall); end
      drain_all();
   endtask

   task automatic test_full_drain();
      for (int k = 0; k < 4; k++) cyc(1'b1, 32'h500 + 32'(k * 4), 32'hC0 + 32'(k), 1'b0);
      cyc(1'b1, 32'h510, 32'hC4, 1'b1);
      @(negedge clk);
      tests++;
      if (Stall !== 1'b0) begin fails++; $display("FAIL full_drain_accept: got %b expected 0", Stall); end
      cyc(1'b1, 32'h514, 32'hC5, 1'b0);
      @(negedge clk);
      tests++;
      if (Stall !== 1'b1) begin fails++; $display("FAIL full_drain_count: got %b expected 1", Stall); end
      drain_all();
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 10; k++) begin
         cyc(1'b1, 32'h600 + 32'(k * 4), 32'h1000 + 32'(k), 1'b1);
         @(negedge clk);
         tests++;
         if (Stall !== 1'b0) begin fails++; $display("FAIL wrap_stall_%0d: got %b expected 0", k, Stall); end
         if (k > 0) begin
            tests++;
            if (bus_addr !== 32'h600 + 32'((k - 1) * 4)) begin
               fails++; $display("FAIL wrap_order_%0d: got %h expected %h", k, bus_addr, 32'h600 + 32'((k - 1) * 4));
            end
         end
      end
      drain_all();
   endtask

   task automatic test_mid_reset();
      for (int k = 0; k < 3; k++) cyc(1'b1, 32'h700 + 32'(k * 4), 32'hE0 + 32'(k), 1'b0);
      cyc(1'b0, 32'h0, 32'h0, 1'b0);
      #2 reset = 1'b0;
      #1;
      tests += 2;
      if (Empty !== 1'b1) begin fails++; $display("FAIL mid_reset_empty: got %b expected 1", Empty); end
      if (bus_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_valid: got %b expected 0", bus_valid); end
      bus_ready = 1'b1;
      @(posedge clk); #1;
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         cyc(1'b0, 32'h0, 32'h0, 1'b1);
         @(negedge clk);
         tests++;
         if (bus_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_no_write_%0d: got %b expected 0", k, bus_valid); end
      end
   endtask

   initial begin
      test_reset();
      test_single_store();
      test_forwarding();
      test_full_stall();
      test_full_drain();
      test_wrap();
      test_mid_reset();
      tests++;
      if (sbq.size() != 0) begin fails++; $display("FAIL scoreboard_leftover: got %0d expected 0", sbq.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
